// File: rtl/alu_pkg.sv
// Shared opcode and compare-result constants for the 4-bit ALU.
// Pure definitions, no logic.
package alu_pkg;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_CMP = 3'b011;
    localparam logic [2:0] OP_SHL = 3'b100;
    localparam logic [2:0] OP_SHR = 3'b101;
    localparam logic [2:0] OP_AND = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    localparam logic [7:0] CMP_EQ = 8'h00;
    localparam logic [7:0] CMP_GT = 8'h01;
    localparam logic [7:0] CMP_LT = 8'h02;
endpackage

// File: rtl/alu_4bit_rca4.sv
// 4-bit ripple-carry adder built from a chain of full adders.
// Latency: combinational.
// Backpressure: none, pure datapath.
module rca4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[4];
endmodule

// File: rtl/alu_4bit.sv
// 4-bit ALU: add/sub/mul/compare/shift/logic with registered 8-bit result and carry.
// Latency: 1 cycle from operand sample to out/cout.
// Backpressure: none, a result is produced every cycle.
module alu_4bit
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  logic [2:0] op,
    output logic       cout,
    output logic [7:0] out
);
    logic [3:0] add_b;
    logic       add_cin;
    logic [3:0] add_sum;
    logic       add_cout;
    logic [7:0] a_ext;
    logic [7:0] prod;
    logic [7:0] nxt_out;
    logic       nxt_cout;

    // SUB reuses the adder as a + ~b + 1; the carry out is then the no-borrow flag
    assign add_b   = (op == OP_SUB) ? ~b : b;
    assign add_cin = (op == OP_SUB) ? 1'b1 : cin;
    assign a_ext   = {4'b0000, a};

    rca4 u_rca4 (
        .a    (a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        prod = 8'h00;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) prod = prod + (a_ext << i);
        end
    end

    always_comb begin
        nxt_out  = 8'h00;
        nxt_cout = 1'b0;
        case (op)
            OP_ADD: begin
                nxt_out  = {4'b0000, add_sum};
                nxt_cout = add_cout;
            end
            OP_SUB: begin
                nxt_out  = {4'b0000, add_sum};
                nxt_cout = add_cout;
            end
            OP_MUL: nxt_out = prod;
            OP_CMP: begin
                if (a < b)      nxt_out = CMP_LT;
                else if (a > b) nxt_out = CMP_GT;
                else            nxt_out = CMP_EQ;
            end
            OP_SHL: nxt_out = a_ext << b[2:0];
            OP_SHR: nxt_out = a_ext >> b[2:0];
            OP_AND: nxt_out = {4'b0000, a & b};
            OP_XOR: nxt_out = {4'b0000, a ^ b};
            default: begin
                nxt_out  = 8'h00;
                nxt_cout = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out  <= 8'h00;
            cout <= 1'b0;
        end else begin
            out  <= nxt_out;
            cout <= nxt_cout;
        end
    end
endmodule

// File: tb/tb_alu_4bit.sv
// Self-checking bench for alu_4bit: directed cases with fixed expectations,
// then a randomized stream with occasional resets checked against a reference model.
module tb_alu_4bit;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [2:0] op;
    logic       cout;
    logic [7:0] out;

    int checks = 0;
    int errors = 0;

    alu_4bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .op    (op),
        .cout  (cout),
        .out   (out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model straight from the operation table, in integer arithmetic
    function automatic void ref_model(input int o, input int x, input int y, input int ci,
                                      output int r_out, output int r_cout);
        int s;
        r_out  = 0;
        r_cout = 0;
        case (o)
            0: begin s = x + y + ci; r_out = s % 16; r_cout = s / 16; end
            1: begin r_out = (x - y + 16) % 16; r_cout = (x >= y) ? 1 : 0; end
            2: r_out = x * y;
            3: r_out = (x < y) ? 2 : ((x > y) ? 1 : 0);
            4: r_out = (x * (1 << (y % 8))) % 256;
            5: r_out = x / (1 << (y % 8));
            6: r_out = x & y;
            default: r_out = x ^ y;
        endcase
    endfunction

    task automatic drive(input bit r, input int o, input int x, input int y, input int ci);
        @(negedge clk);
        rst_n = r;
        op    = 3'(o);
        a     = 4'(x);
        b     = 4'(y);
        cin   = 1'(ci);
        @(posedge clk);
        #1;
    endtask

    task automatic dir(input string tag, input int o, input int x, input int y, input int ci,
                       input int e_out, input int e_cout);
        drive(1'b1, o, x, y, ci);
        chk({tag, ".out"}, int'(out), e_out);
        chk({tag, ".cout"}, int'(cout), e_cout);
    endtask

    initial begin
        int o, x, y, ci, e_out, e_cout;
        bit r;
        rst_n = 1'b0; op = 3'd0; a = 4'hF; b = 4'hF; cin = 1'b1;

        // Reset held two cycles with ADD 15+15+1 on the inputs
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 0, 15, 15, 1);
            chk("rst.out", int'(out), 0);
            chk("rst.cout", int'(cout), 0);
        end
        dir("rel_add", 0, 15, 15, 0, 8'h0E, 1);

        dir("add_1_1_1", 0, 1, 1, 1, 8'h03, 0);
        dir("add_wrap", 0, 15, 15, 1, 8'h0F, 1);
        dir("add_3_3", 0, 3, 3, 0, 8'h06, 0);
        dir("sub_4_2", 1, 4, 2, 0, 8'h02, 1);
        dir("sub_5_9", 1, 5, 9, 1, 8'h0C, 0);
        dir("sub_6_6", 1, 6, 6, 0, 8'h00, 1);
        dir("mul_7_7", 2, 7, 7, 1, 8'h31, 0);
        dir("mul_8_8", 2, 8, 8, 0, 8'h40, 0);
        dir("mul_max", 2, 15, 15, 0, 8'hE1, 0);
        dir("cmp_lt", 3, 2, 3, 0, 8'h02, 0);
        dir("cmp_gt", 3, 3, 2, 0, 8'h01, 0);
        dir("cmp_eq", 3, 3, 3, 1, 8'h00, 0);
        dir("shl_8_2", 4, 8, 2, 0, 8'h20, 0);
        dir("shl_3_3", 4, 3, 3, 0, 8'h18, 0);
        dir("shl_max", 4, 15, 7, 1, 8'h80, 0);
        dir("shl_b3_ign", 4, 3, 9, 0, 8'h06, 0);
        dir("shr_6_2", 5, 6, 2, 0, 8'h01, 0);
        dir("shr_3_7", 5, 3, 7, 0, 8'h00, 0);
        dir("shr_b3_ign", 5, 12, 10, 0, 8'h03, 0);
        dir("and_c_a", 6, 12, 10, 1, 8'h08, 0);
        dir("xor_c_a", 7, 12, 10, 1, 8'h06, 0);

        // Mid-stream reset with an op that would otherwise give a nonzero result
        drive(1'b0, 2, 15, 15, 1);
        chk("midrst.out", int'(out), 0);
        chk("midrst.cout", int'(cout), 0);

        // Random stream: new op/operands every cycle, sporadic resets
        for (int n = 0; n < 400; n++) begin
            o  = int'($urandom_range(0, 7));
            x  = int'($urandom_range(0, 15));
            y  = int'($urandom_range(0, 15));
            ci = int'($urandom_range(0, 1));
            r  = ($urandom_range(0, 15) != 0);
            drive(r, o, x, y, ci);
            if (r) ref_model(o, x, y, ci, e_out, e_cout);
            else begin e_out = 0; e_cout = 0; end
            chk("rand.out", int'(out), e_out);
            chk("rand.cout", int'(cout), e_cout);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
